load_store_unit: RTL and testbench

Data-side memory stage of the RISC-V core, sitting directly downstream of the main decoder and ALU. It consumes the decoder's MemWrite / MemRead / DataType / DataSize controls plus the ALU-computed address and rs2 data. It runs word-wide transactions on a ready-handshaked data bus, splitting misaligned half/word accesses into two beats, and returns a size- and sign-extended load result. Stall holds the core (PC and register write) until the access completes.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 219 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-side memory bus between the load/store unit and the data memory.
// Word-wide beats qualified by mem_req and completed by mem_ready.
//   mem_req    master->slave  beat request, held until accepted
//   mem_we     master->slave  1 = write beat
//   mem_addr   master->slave  word-aligned beat address
//   mem_be     master->slave  byte-lane enables (bit i = lane i)
//   mem_wdata  master->slave  lane-aligned write data
//   mem_rdata  slave->master  read data, valid with mem_req & mem_ready
//   mem_ready  slave->master  beat accepted/completed this cycle
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: data-side memory stage of the core.
// Turns one load/store instruction into one or two word beats on the data
// bus (misaligned half/word accesses split across two words) and returns a
// size- and sign-extended load result.
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   MemRead/MemWrite  load/store request (write wins when both set)
//   DataType          0 = sign-extend load, 1 = zero-extend
//   DataSize          00 word, 01 half, 10 byte, 11 word
//   Address           byte address from the ALU
//   WriteData         store data (rs2)
//   ReadData          extended load result, valid in DONE
//   Stall             hold PC / suppress RegWrite while the access runs
//   SplitAccess       current access needs two beats
//   bus               data memory bus (master side)
//
// state | meaning
// IDLE  | no access; on op latch beat 0/1 controls and stall the core
// BEAT0 | first beat on the bus, waiting for mem_ready
// BEAT1 | second beat of a split access, waiting for mem_ready
// DONE  | result presented for one cycle, core released
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              DataType,
  input  logic [1:0]        DataSize,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              SplitAccess,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

  state_e state_q, state_d;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              split_q, split_d;
  logic [ADDR_W-1:0] b1_addr_q, b1_addr_d;
  logic [3:0]        b1_be_q, b1_be_d;
  logic [31:0]       b1_wdata_q, b1_wdata_d;
  logic [31:0]       r0_q, r0_d;
  logic [31:0]       r1_q, r1_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              dtype_q, dtype_d;
  logic              wr_q, wr_d;

  logic              op;
  logic [1:0]        off;
  logic              is_byte, is_half, is_word, split;
  logic [3:0]        size_mask;
  logic [7:0]        be_span;
  logic [63:0]       wdata_span;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_req;
  logic              stall_raw;
  logic [63:0]       raw64;
  logic [31:0]       raw;
  logic              unused_raw_hi;

  // Request decode. Lanes/data are shifted across a two-word span so the
  // low half is beat 0 and the high half is beat 1 of a split access.
  always_comb begin
    op         = MemRead | MemWrite;
    off        = Address[1:0];
    base_addr  = {Address[ADDR_W-1:2], 2'b00};
    is_byte    = (DataSize == 2'b10);
    is_half    = (DataSize == 2'b01);
    is_word    = !is_byte && !is_half;
    size_mask  = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
    be_span    = {4'b0000, size_mask} << off;
    wdata_span = {32'h0, WriteData} << {off, 3'b000};
    split      = (is_half && (off == 2'b11)) || (is_word && (off != 2'b00));
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    split_d     = split_q;
    b1_addr_d   = b1_addr_q;
    b1_be_d     = b1_be_q;
    b1_wdata_d  = b1_wdata_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    off_d       = off_q;
    size_d      = size_q;
    dtype_d     = dtype_q;
    wr_d        = wr_q;
    mem_req     = 1'b0;
    stall_raw   = 1'b0;

    case (state_q)
      IDLE: begin
        if (op) begin
          stall_raw   = 1'b1;
          state_d     = BEAT0;
          mem_we_d    = MemWrite;
          mem_addr_d  = base_addr;
          mem_be_d    = be_span[3:0];
          mem_wdata_d = wdata_span[31:0];
          b1_addr_d   = base_addr + ADDR_W'(4);
          b1_be_d     = be_span[7:4];
          b1_wdata_d  = wdata_span[63:32];
          split_d     = split;
          off_d       = off;
          size_d      = DataSize;
          dtype_d     = DataType;
          wr_d        = MemWrite;
          // R1 must read as zero for single-beat loads
          r0_d        = 32'h0;
          r1_d        = 32'h0;
        end
      end
      BEAT0: begin
        mem_req   = 1'b1;
        stall_raw = 1'b1;
        if (bus.mem_ready) begin
          if (!wr_q) r0_d = bus.mem_rdata;
          if (split_q) begin
            state_d     = BEAT1;
            mem_addr_d  = b1_addr_q;
            mem_be_d    = b1_be_q;
            mem_wdata_d = b1_wdata_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      BEAT1: begin
        mem_req   = 1'b1;
        stall_raw = 1'b1;
        if (bus.mem_ready) begin
          if (!wr_q) r1_d = bus.mem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      split_q     <= 1'b0;
      b1_addr_q   <= '0;
      b1_be_q     <= 4'h0;
      b1_wdata_q  <= 32'h0;
      r0_q        <= 32'h0;
      r1_q        <= 32'h0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      dtype_q     <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      split_q     <= split_d;
      b1_addr_q   <= b1_addr_d;
      b1_be_q     <= b1_be_d;
      b1_wdata_q  <= b1_wdata_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      off_q       <= off_d;
      size_q      <= size_d;
      dtype_q     <= dtype_d;
      wr_q        <= wr_d;
    end
  end

  // Load result: pick the addressed bytes out of {R1, R0}, then extend.
  always_comb begin
    raw64 = {r1_q, r0_q} >> {off_q, 3'b000};
    raw   = raw64[31:0];
    case (size_q)
      2'b10:   ReadData = dtype_q ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ReadData = dtype_q ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ReadData = raw;
    endcase
    if (wr_q) ReadData = 32'h0;
  end

  // Shift is at most 24 bits, so the top word of the span is never selected.
  assign unused_raw_hi = ^raw64[63:32];

  // Stall is gated by rst_n so the core is released while reset is held.
  assign Stall         = stall_raw & rst_n;
  assign SplitAccess   = split_q;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead, MemWrite, DataType;
  logic [1:0]  DataSize;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        Stall, SplitAccess;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .DataType    (DataType),
    .DataSize    (DataSize),
    .Address     (Address),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .SplitAccess (SplitAccess),
    .bus         (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    int          stall_cycles;
    logic        split;
  } res_t;

  beat_t exp_beats[$];
  res_t  exp_res[$];
  int    wait_plan[$];
  logic [7:0] mem_model [bit [31:0]];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) mem_model[a + k] = v[8*k +: 8];
  endtask

  // Reference: an access touches n consecutive bytes; each distinct word
  // they fall into is one beat. Called at posedge+2 with the DUT in IDLE.
  task automatic issue(input logic rd, input logic wr, input logic dtype,
                       input logic [1:0] dsize, input logic [31:0] addr,
                       input logic [31:0] wd, input int w0, input int w1);
    int          n;
    int          nb;
    bit          have;
    beat_t       b;
    logic [31:0] ba;
    logic [31:0] wa;
    logic [1:0]  lane;
    logic [31:0] val;
    res_t        r;
    bit          done;
    n    = (dsize == 2'b10) ? 1 : ((dsize == 2'b01) ? 2 : 4);
    nb   = 0;
    have = 0;
    b    = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0};
    val  = 32'h0;
    for (int k = 0; k < n; k++) begin
      ba   = addr + 32'(k);
      wa   = {ba[31:2], 2'b00};
      lane = ba[1:0];
      if (!have || wa != b.addr) begin
        if (have) exp_beats.push_back(b);
        b    = '{addr: wa, be: 4'h0, we: wr, wdata: 32'h0};
        have = 1;
        nb++;
      end
      b.be[lane] = 1'b1;
      b.wdata[8*lane +: 8] = wd[8*k +: 8];
      val[8*k +: 8] = rd_byte(ba);
    end
    exp_beats.push_back(b);
    if (n == 1) val = dtype ? {24'h0, val[7:0]} : {{24{val[7]}}, val[7:0]};
    if (n == 2) val = dtype ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
    if (wr) begin
      for (int k = 0; k < n; k++) mem_model[addr + 32'(k)] = wd[8*k +: 8];
      val = 32'h0;
    end
    wait_plan.push_back(w0);
    if (nb == 2) wait_plan.push_back(w1);
    r.rdata        = val;
    r.stall_cycles = 1 + nb + w0 + ((nb == 2) ? w1 : 0);
    r.split        = (nb == 2);
    exp_res.push_back(r);

    MemRead   = rd;
    MemWrite  = wr;
    DataType  = dtype;
    DataSize  = dsize;
    Address   = addr;
    WriteData = wd;
    done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no completion at addr %h expected DONE within 100 cycles", addr);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle_gap(input int n);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Address  = $urandom;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Memory responder: per-beat wait counts come from wait_plan.
  int wait_left;
  bit in_beat;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    in_beat       = 0;
    wait_left     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.mem_ready = 1'b0;
        in_beat       = 0;
      end else if (!bus.mem_req) begin
        in_beat       = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end else begin
        if (!in_beat) begin
          in_beat   = 1;
          wait_left = (wait_plan.size() > 0) ? wait_plan.pop_front() : 0;
        end
        if (wait_left == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd_word(bus.mem_addr);
          in_beat       = 0;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
          wait_left--;
        end
      end
    end
  end

  // Monitor: checks beats, bus stability during waits and DONE results.
  initial begin
    logic        prev_stall, prev_req, prev_ready, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_be;
    int          stall_cnt;
    beat_t       b;
    res_t        r;
    prev_stall = 0; prev_req = 0; prev_ready = 0; prev_we = 0;
    prev_addr = 0; prev_wdata = 0; prev_be = 0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0; prev_req = 0; prev_ready = 0;
        stall_cnt  = 0;
      end else begin
        if (Stall) stall_cnt++;
        if (bus.mem_req && prev_req && !prev_ready) begin
          check("hold_addr", bus.mem_addr, prev_addr);
          check("hold_be_we", {27'h0, bus.mem_be, bus.mem_we}, {27'h0, prev_be, prev_we});
          check("hold_wdata", bus.mem_wdata, prev_wdata);
        end
        if (bus.mem_req && bus.mem_ready) begin
          if (exp_beats.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat at %h expected none", bus.mem_addr);
          end else begin
            b = exp_beats.pop_front();
            check("beat_addr", bus.mem_addr, b.addr);
            check("beat_be", {28'h0, bus.mem_be}, {28'h0, b.be});
            check("beat_we", {31'h0, bus.mem_we}, {31'h0, b.we});
            if (b.we) check("beat_wdata", bus.mem_wdata & lane_mask(b.be), b.wdata);
          end
        end
        if (prev_stall && !Stall) begin
          if (exp_res.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got ReadData %h expected no completion", ReadData);
          end else begin
            r = exp_res.pop_front();
            check("read_data", ReadData, r.rdata);
            check("stall_cycles", 32'(stall_cnt), 32'(r.stall_cycles));
            check("split_access", {31'h0, SplitAccess}, {31'h0, r.split});
          end
          stall_cnt = 0;
        end
        prev_stall = Stall;
        prev_req   = bus.mem_req;
        prev_ready = bus.mem_ready;
        prev_addr  = bus.mem_addr;
        prev_be    = bus.mem_be;
        prev_we    = bus.mem_we;
        prev_wdata = bus.mem_wdata;
      end
    end
  end

  initial begin
    int sel;
    logic [31:0] a;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    DataType  = 1'b0;
    DataSize  = 2'b00;
    Address   = 32'h100;
    WriteData = 32'h0;

    // reset values, with a load request present to show Stall is forced low
    @(posedge clk);
    #2;
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_stall", {31'h0, Stall}, 32'h0);
    check("rst_read_data", ReadData, 32'h0);
    check("rst_split", {31'h0, SplitAccess}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_be_we", {27'h0, bus.mem_be, bus.mem_we}, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    MemRead = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #2;

    // directed cases
    poke_word(32'h100, 32'hDEADBEEF);
    issue(1, 0, 0, 2'b00, 32'h100, 32'h0, 0, 0);                 // lw 0x100
    mem_model[32'h203] = 8'h80;
    issue(1, 0, 0, 2'b10, 32'h203, 32'h0, 0, 0);                 // lb
    issue(1, 0, 1, 2'b10, 32'h203, 32'h0, 1, 0);                 // lbu
    issue(0, 1, 0, 2'b01, 32'h103, 32'h0000ABCD, 0, 0);          // sh split
    poke_word(32'h100, 32'h3344_0000);
    poke_word(32'h104, 32'h0000_1122);
    issue(1, 0, 0, 2'b00, 32'h102, 32'h0, 0, 2);                 // lw split + waits
    issue(1, 0, 0, 2'b00, 32'hFFFFFFFE, 32'h0, 0, 0);            // wrap
    issue(1, 0, 0, 2'b01, 32'h101, 32'h0, 0, 0);                 // lh, no split
    issue(1, 0, 0, 2'b11, 32'h105, 32'h0, 1, 1);                 // size 11 as word
    issue(1, 1, 0, 2'b00, 32'h180, 32'h12345678, 0, 0);          // both: write
    idle_gap(2);

    // reset during BEAT0 of a load that is still waiting
    wait_plan.push_back(6);
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    DataSize = 2'b00;
    Address  = 32'h140;
    @(posedge clk);
    #2;
    check("beat0_req", {31'h0, bus.mem_req}, 32'h1);
    check("beat0_stall", {31'h0, Stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_req", {31'h0, bus.mem_req}, 32'h0);
    check("abort_stall", {31'h0, Stall}, 32'h0);
    MemRead = 1'b0;
    wait_plan.delete();
    @(posedge clk);
    #2;
    check("abort_read_data", ReadData, 32'h0);
    check("abort_be", {28'h0, bus.mem_be}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("post_rst_stall", {31'h0, Stall}, 32'h0);
    issue(1, 0, 0, 2'b00, 32'h100, 32'h0, 0, 0);

    // randomized traffic, back-to-back with occasional gaps
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_gap($urandom_range(1, 3));
      end else begin
        sel = $urandom_range(0, 2);
        a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                         : (32'h100 + 32'($urandom_range(0, 63)));
        issue((sel != 1), (sel != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
      end
    end
    idle_gap(3);

    check("beats_drained", 32'(exp_beats.size()), 32'h0);
    check("results_drained", 32'(exp_res.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test expected finish before 500000");
    $fatal(1);
  end

endmodule
